// File: rtl/clock_divider.sv
// clock_divider: derives a 50%-duty clock toggling every D clk_in cycles (period 2*D).
// Optional macro CLOCK_DIVIDER_TICK_EN adds a registered one-cycle tick on each clk_out toggle.
module clock_divider #(
    parameter int D = 2
) (
    input  logic clk_in,
    input  logic rst,
`ifdef CLOCK_DIVIDER_TICK_EN
    output logic tick,
`endif
    output logic clk_out
);

    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] LAST = CW'((D > 1) ? (D - 1) : 0);

    generate
        if (D < 1) begin : g_bad_d
            $error("clock_divider: parameter D must be >= 1");
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic          wrap;

    generate
        if (D == 1) begin : g_div2
            always_comb wrap = 1'b1;
        end else begin : g_divn
            // >= rather than == so any unreachable code recovers on the next edge
            always_comb wrap = (cnt >= LAST);
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt     <= cnt + CW'(1);
        end
    end

`ifdef CLOCK_DIVIDER_TICK_EN
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            tick <= 1'b0;
        end else begin
            tick <= wrap;
        end
    end
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: instances with D = 1, 2, 3, 4, 7 share one clock and reset.
module tb_clock_divider;

    localparam int NI = 5;
    localparam int DV [NI] = '{1, 2, 3, 4, 7};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NI-1:0] co;
    logic [NI-1:0] tk;

    always #5 clk = ~clk;

`ifdef CLOCK_DIVIDER_TICK_EN
    clock_divider #(.D(1)) u_d1 (.clk_in(clk), .rst(rst), .tick(tk[0]), .clk_out(co[0]));
    clock_divider #(.D(2)) u_d2 (.clk_in(clk), .rst(rst), .tick(tk[1]), .clk_out(co[1]));
    clock_divider #(.D(3)) u_d3 (.clk_in(clk), .rst(rst), .tick(tk[2]), .clk_out(co[2]));
    clock_divider #(.D(4)) u_d4 (.clk_in(clk), .rst(rst), .tick(tk[3]), .clk_out(co[3]));
    clock_divider #(.D(7)) u_d7 (.clk_in(clk), .rst(rst), .tick(tk[4]), .clk_out(co[4]));
`else
    assign tk = '0;
    clock_divider #(.D(1)) u_d1 (.clk_in(clk), .rst(rst), .clk_out(co[0]));
    clock_divider #(.D(2)) u_d2 (.clk_in(clk), .rst(rst), .clk_out(co[1]));
    clock_divider #(.D(3)) u_d3 (.clk_in(clk), .rst(rst), .clk_out(co[2]));
    clock_divider #(.D(4)) u_d4 (.clk_in(clk), .rst(rst), .clk_out(co[3]));
    clock_divider #(.D(7)) u_d7 (.clk_in(clk), .rst(rst), .clk_out(co[4]));
`endif

    typedef struct {
        int            n;
        logic [NI-1:0] clk_e;
        logic [NI-1:0] tick_e;
    } exp_t;

    typedef struct {
        int   edge_n;
        logic exp_d3;
        logic exp_tick_d4;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[12];

    int   checks = 0;
    int   errors = 0;
    int   n      = 0;
    int   max_cnt7 = 0;
    int   rises2 = 0;
    logic prev2  = 1'b0;

    // Edge n counts rising edges since reset release; clk_out flips every D of them.
    function automatic logic model_clk(int d, int k);
        return ((k / d) % 2) == 1;
    endfunction

    function automatic logic model_tick(int d, int k);
        return (k > 0) && ((k % d) == 0);
    endfunction

    task automatic check_bit(string name, int d, int k, logic got, logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s D=%0d edge=%0d got=%b want=%b", name, d, k, got, want);
        end
    endtask

    task automatic step();
        exp_t e;
        exp_t g;
        @(posedge clk);
        n++;
        e.n = n;
        for (int i = 0; i < NI; i++) begin
            e.clk_e[i]  = model_clk(DV[i], n);
            e.tick_e[i] = model_tick(DV[i], n);
        end
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        checks++;
        if ($isunknown(co)) begin
            errors++;
            $display("FAIL clk_out_x edge=%0d got=%b want=no X", g.n, co);
        end
        for (int i = 0; i < NI; i++) begin
            check_bit("clk_out", DV[i], g.n, co[i], g.clk_e[i]);
`ifdef CLOCK_DIVIDER_TICK_EN
            check_bit("tick", DV[i], g.n, tk[i], g.tick_e[i]);
`endif
        end
        if (int'(u_d7.cnt) > max_cnt7) max_cnt7 = int'(u_d7.cnt);
        if (co[1] && !prev2) rises2++;
        prev2 = co[1];
    endtask

    task automatic check_reset_state(string name);
        checks++;
        if (co !== '0) begin
            errors++;
            $display("FAIL %s clk_out got=%b want=%b", name, co, {NI{1'b0}});
        end
        checks++;
        if (tk !== '0) begin
            errors++;
            $display("FAIL %s tick got=%b want=%b", name, tk, {NI{1'b0}});
        end
    endtask

    initial begin
        tbl[0]  = '{1,  1'b0, 1'b0};
        tbl[1]  = '{2,  1'b0, 1'b0};
        tbl[2]  = '{3,  1'b1, 1'b0};
        tbl[3]  = '{4,  1'b1, 1'b1};
        tbl[4]  = '{5,  1'b1, 1'b0};
        tbl[5]  = '{6,  1'b0, 1'b0};
        tbl[6]  = '{7,  1'b0, 1'b0};
        tbl[7]  = '{8,  1'b0, 1'b1};
        tbl[8]  = '{9,  1'b1, 1'b0};
        tbl[9]  = '{10, 1'b1, 1'b0};
        tbl[10] = '{11, 1'b1, 1'b0};
        tbl[11] = '{12, 1'b0, 1'b1};

        // Reset held for 10 cycles, released between edges.
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_reset_state("reset_hold");
        end
        rst = 1'b1;
        n   = 0;

        foreach (tbl[i]) begin
            step();
            check_bit("tbl_edge", 3, n, 1'(n == tbl[i].edge_n), 1'b1);
            check_bit("tbl_clk_out", 3, n, co[2], tbl[i].exp_d3);
`ifdef CLOCK_DIVIDER_TICK_EN
            check_bit("tbl_tick", 4, n, tk[3], tbl[i].exp_tick_d4);
`endif
        end

        while (n < 100) step();
        checks++;
        if (max_cnt7 != 6) begin
            errors++;
            $display("FAIL d7_cnt_max got=%0d want=6", max_cnt7);
        end

        // Asynchronous reset while the D=3 output is high, between edges.
        for (int k = 0; k < 8 && !model_clk(3, n); k++) step();
        check_bit("pre_async_high", 3, n, co[2], 1'b1);
        #2 rst = 1'b0;
        #1 check_reset_state("async_reset");
        repeat (3) begin
            @(negedge clk);
            check_reset_state("reset_hold2");
        end
        rst    = 1'b1;
        n      = 0;
        rises2 = 0;
        prev2  = 1'b0;

        step();
        step();
        check_bit("rerise_edge2", 3, n, co[2], 1'b0);
        step();
        check_bit("rerise_edge3", 3, n, co[2], 1'b1);

        while (n < 1000) step();
        checks++;
        if (rises2 < 249 || rises2 > 251) begin
            errors++;
            $display("FAIL d2_rise_count got=%0d want=250+-1", rises2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
